pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MULT_CYCLES, default 4, number of cycles the HI/LO multiplier stays busy after a mult enters EX; legal range 2..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  the instruction in ID reads rs / rt.
REQ-006 id_hilo  in  1  the instruction in ID is mult, mfhi, mflo, mthi or mtlo.
REQ-007 ex_lw  in  1  a load (lw, lb or lbu) is in EX.
REQ-008 ex_rt  in  5  destination register of the load in EX.
REQ-009 ex_mult  in  1  a mult is in EX this cycle.
REQ-010 ex_branch_taken  in  1  a branch or jump resolved taken in EX.
REQ-011 ex_syscall, ex_eret  in  1 each  a syscall / eret is in EX.
REQ-012 pc_stall  out  1  hold the PC.
REQ-013 if_id_stall  out  1  hold the IF/ID register.
REQ-014 if_id_flush  out  1  zero the IF/ID register.
REQ-015 id_ex_bubble  out  1  drives the bubble input of ID/EX.
REQ-016 pc_sel  out  2  next-PC source: 00 sequential, 01 branch/jump target, 10 exception vector, 11 EPC.
REQ-017 epc_we  out  1  one-cycle EPC write strobe.
REQ-018 mult_busy  out  1  the multiplier is occupied.
REQ-019 in_exc  out  1  the handler is executing (between syscall and eret).

Function
REQ-020 Load-use hazard (LU) SHALL be ex_lw & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
REQ-021 HILO hazard (HH) SHALL be mult_busy & id_hilo.
REQ-022 Flush condition FL SHALL be ex_branch_taken | ex_syscall accepted | ex_eret | (state==EXC_DRAIN).
REQ-023 LU or HH with FL=0 SHALL assert pc_stall=1, if_id_stall=1 and id_ex_bubble=1 in the same cycle (combinational); pc_sel SHALL be 00.
REQ-024 LU SHALL last exactly one cycle; HH SHALL repeat every cycle until mult_busy falls.
REQ-025 FL=1 SHALL force if_id_flush=1, id_ex_bubble=1, pc_stall=0 and if_id_stall=0, and SHALL suppress LU and HH stalls.
REQ-026 Priority for pc_sel: accepted ex_syscall (10) > ex_eret (11) > ex_branch_taken (01) > 00.
REQ-027 The FSM SHALL have two states, RUN and EXC_DRAIN; it resets to RUN.
REQ-028 RUN->EXC_DRAIN SHALL occur on an accepted syscall, i.e. ex_syscall & !in_exc; in that cycle epc_we=1 and pc_sel=10.
REQ-029 EXC_DRAIN SHALL last exactly one cycle and then return to RUN; in it FL=1, pc_sel=00 and epc_we=0.
REQ-030 in_exc SHALL set on the clock edge that accepts a syscall.
REQ-031 in_exc SHALL clear on the clock edge at which ex_eret=1.
REQ-032 ex_syscall while in_exc=1 SHALL be ignored: no epc_we, no vector, no state change; it still flushes only if another FL source is active.
REQ-033 Mult counter: ex_mult=1 SHALL load cnt=MULT_CYCLES-1 and set mult_busy on the next edge.
REQ-034 While busy the counter SHALL decrement once per cycle; mult_busy SHALL clear on the edge where cnt==0, giving MULT_CYCLES busy cycles.
REQ-035 ex_mult while already busy SHALL reload the counter (restart).
REQ-036 The counter SHALL be independent of the FSM; a syscall, eret or branch does not cancel a mult already in EX.
REQ-037 ex_syscall and ex_eret asserted together SHALL be treated as a syscall (eret ignored, in_exc unaffected by eret).

Reset
REQ-038 While rst=1: state=RUN, cnt=0, mult_busy=0, in_exc=0.
REQ-039 After reset, all combinational outputs SHALL follow the rules above with inactive inputs: pc_stall=0, if_id_stall=0, if_id_flush=0, id_ex_bubble=0, pc_sel=00, epc_we=0.
REQ-040 Reset asserted mid-mult or in EXC_DRAIN SHALL abort immediately and asynchronously to the reset values.

Verification
REQ-041 Scenario: ex_lw=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1; with ex_rt=0 -> no stall.
REQ-042 Scenario: MULT_CYCLES=4, ex_mult pulse, then id_hilo=1 held -> mult_busy high 4 cycles, stall+bubble on each of them, released the cycle mult_busy falls.
REQ-043 Scenario: ex_branch_taken=1 with LU also true -> if_id_flush=1, id_ex_bubble=1, pc_sel=01, pc_stall=0.
REQ-044 Scenario: ex_syscall=1 with in_exc=0 -> epc_we=1, pc_sel=10, next cycle EXC_DRAIN flush, in_exc=1; a second syscall -> ignored; ex_eret -> pc_sel=11, in_exc=0 next cycle.
REQ-045 Scenario: rst pulse during cycle 2 of a mult and again in EXC_DRAIN -> mult_busy=0, in_exc=0, state=RUN without waiting for a clock edge.
REQ-046 Scenario: ex_syscall and ex_eret together, plus ex_branch_taken -> pc_sel=10, epc_we=1, in_exc=1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, flush, PC-select and exception control for a 5-stage pipeline
module pipeline_ctrl #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_hilo,
  input  logic       ex_lw,
  input  logic [4:0] ex_rt,
  input  logic       ex_mult,
  input  logic       ex_branch_taken,
  input  logic       ex_syscall,
  input  logic       ex_eret,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic [1:0] pc_sel,
  output logic       epc_we,
  output logic       mult_busy,
  output logic       in_exc
);

  typedef enum logic {RUN, EXC_DRAIN} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MULT_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       sys_acc, eret_eff, lu, hh, fl;

  // A syscall issued together with eret wins; the eret is dropped entirely.
  assign sys_acc  = ex_syscall & ~in_exc;
  assign eret_eff = ex_eret & ~ex_syscall;

  assign lu = ex_lw & (ex_rt != 5'd0) &
              ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign hh = mult_busy & id_hilo;
  assign fl = ex_branch_taken | sys_acc | eret_eff | (state == EXC_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = RUN;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_sel       = 2'b00;
    epc_we       = 1'b0;
    if (fl) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu | hh) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
    case (state)
      RUN: begin
        if (sys_acc) begin
          state_nx = EXC_DRAIN;
          pc_sel   = 2'b10;
          epc_we   = 1'b1;
        end else if (eret_eff) begin
          pc_sel = 2'b11;
        end else if (ex_branch_taken) begin
          pc_sel = 2'b01;
        end
      end
      EXC_DRAIN: state_nx = RUN;
      default:   state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_exc <= 1'b0;
    end else if (sys_acc) begin
      in_exc <= 1'b1;
    end else if (eret_eff) begin
      in_exc <= 1'b0;
    end
  end

  // Multiplier occupancy runs on its own; pipeline flushes never cancel it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      mult_busy <= 1'b0;
    end else if (ex_mult) begin
      cnt       <= CNT_LOAD;
      mult_busy <= 1'b1;
    end else if (mult_busy) begin
      if (cnt == 4'd0) begin
        mult_busy <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_hilo, ex_lw, ex_mult;
  logic       ex_branch_taken, ex_syscall, ex_eret;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, epc_we, mult_busy, in_exc;
  logic [1:0] pc_sel;

  int n_cmp = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.MULT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo(id_hilo), .ex_lw(ex_lw), .ex_rt(ex_rt), .ex_mult(ex_mult),
    .ex_branch_taken(ex_branch_taken), .ex_syscall(ex_syscall), .ex_eret(ex_eret),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_sel(pc_sel), .epc_we(epc_we),
    .mult_busy(mult_busy), .in_exc(in_exc)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_sel, epc_we, mult_busy, in_exc}
  function automatic logic [8:0] obs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_sel, epc_we, mult_busy, in_exc};
  endfunction

  // {lw, ex_rt, id_rs, uses_rs, id_rt, uses_rt, hilo, mult, br, sys, eret}
  function automatic logic [22:0] st(input logic lw, input logic [4:0] ert, input logic [4:0] rs,
                                     input logic urs, input logic [4:0] rt, input logic urt,
                                     input logic hilo, input logic mult, input logic br,
                                     input logic sys, input logic eret);
    return {lw, ert, rs, urs, rt, urt, hilo, mult, br, sys, eret};
  endfunction

  task automatic apply(input logic [22:0] s);
    {ex_lw, ex_rt, id_rs, id_uses_rs, id_rt, id_uses_rt, id_hilo, ex_mult,
     ex_branch_taken, ex_syscall, ex_eret} = s;
  endtask

  task automatic test_reset();
    logic [8:0] e, got;
    apply('0);
    rst = 1'b1;
    exp_q.push_back(9'b0);
    @(negedge clk);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL reset got=%b exp=%b", got, e); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [22:0] s[5];
    logic [8:0]  ev[5];
    logic [8:0]  e, got;
    s[0] = st(1, 8, 8, 1, 0, 0, 0, 0, 0, 0, 0); ev[0] = 9'b1101_00_000;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[1] = 9'b0;
    s[2] = st(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); ev[2] = 9'b0;
    s[3] = st(1, 9, 3, 1, 9, 0, 0, 0, 0, 0, 0); ev[3] = 9'b0;
    s[4] = st(1, 9, 3, 1, 9, 1, 0, 0, 0, 0, 0); ev[4] = 9'b1101_00_000;
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hilo();
    logic [8:0] e, got;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      else        apply(st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      exp_q.push_back((i >= 1 && i <= 4) ? 9'b1101_00_010 : 9'b0);
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL hilo[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult_restart();
    logic [8:0] e, got;
    for (int i = 0; i < 8; i++) begin
      apply(st(0, 0, 0, 0, 0, 0, 0, (i == 0 || i == 2), 0, 0, 0));
      exp_q.push_back((i >= 1 && i <= 6) ? 9'b0000_00_010 : 9'b0);
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL mult_restart[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_lu();
    logic [8:0] e, got;
    apply(st(1, 8, 8, 1, 0, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(9'b0011_01_000);
    @(negedge clk);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL branch_lu got=%b exp=%b", got, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_syscall();
    logic [22:0] s[6];
    logic [8:0]  ev[6];
    logic [8:0]  e, got;
    s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ev[0] = 9'b0011_10_100;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[1] = 9'b0011_00_001;
    s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[2] = 9'b0000_00_001;
    s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ev[3] = 9'b0000_00_001;
    s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); ev[4] = 9'b0011_11_001;
    s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[5] = 9'b0;
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL syscall[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sys_eret();
    logic [22:0] s[4];
    logic [8:0]  ev[4];
    logic [8:0]  e, got;
    s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); ev[0] = 9'b0011_10_100;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[1] = 9'b0011_00_001;
    s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); ev[2] = 9'b0011_11_001;
    s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = 9'b0;
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL sys_eret[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [8:0] e, got;
    apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    apply('0);
    @(posedge clk); #1;
    exp_q.push_back(9'b0000_00_010);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL abort_mult_pre got=%b exp=%b", got, e); end
    rst = 1'b1; #1;
    exp_q.push_back(9'b0);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL abort_mult got=%b exp=%b", got, e); end
    rst = 1'b0;
    @(posedge clk); #1;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    apply('0);
    exp_q.push_back(9'b0011_00_001);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL abort_drain_pre got=%b exp=%b", got, e); end
    rst = 1'b1; #1;
    exp_q.push_back(9'b0);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL abort_drain got=%b exp=%b", got, e); end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(9'b0);
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL abort_after got=%b exp=%b", got, e); end
  endtask

  initial begin
    rst = 1'b1;
    apply('0);
    #2;
    test_reset();
    test_load_use();
    test_hilo();
    test_mult_restart();
    test_branch_lu();
    test_syscall();
    test_sys_eret();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
